// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared widths, FSM encodings and EX field bundle for the ID/EX stage
package id_ex_stage_pkg;

  localparam int XLEN    = 32;
  localparam int ALUOP_W = 4;

  localparam logic [ALUOP_W-1:0] ALUOP_NOP = '0;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } state_t;

  typedef struct packed {
    logic               valid;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic [XLEN-1:0]    imm;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic [ALUOP_W-1:0] alu_op;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
  } ex_fields_t;

  // Register indices of zero keep the forwarding unit from matching a bubble.
  function automatic ex_fields_t bubble_fields();
    ex_fields_t f;
    f        = '0;
    f.alu_op = ALUOP_NOP;
    return f;
  endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// rtl/id_ex_stage_load_use_detect.sv - combinational load-use hazard term between EX load and ID consumer
module load_use_detect (
  input  logic       valid_id,
  input  logic       valid_ex,
  input  logic       mem_read_ex,
  input  logic [4:0] rd_ex,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       rs1_used_id,
  input  logic       rs2_used_id,
  output logic       hazard
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = rs1_used_id & (rs1_id == rd_ex);
  assign rs2_match = rs2_used_id & (rs2_id == rd_ex);

  // x0 is never a real producer, so a load to x0 cannot cause a stall.
  assign hazard = valid_id & valid_ex & mem_read_ex & (rd_ex != 5'd0)
                & (rs1_match | rs2_match);

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble insertion; ID_EX_PERF_CNT_EN adds bubble_cnt
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_id,
  input  logic [XLEN-1:0]    pc_id,
  input  logic [XLEN-1:0]    rs1_data_id,
  input  logic [XLEN-1:0]    rs2_data_id,
  input  logic [XLEN-1:0]    imm_id,
  input  logic [4:0]         rs1_id,
  input  logic [4:0]         rs2_id,
  input  logic               rs1_used_id,
  input  logic               rs2_used_id,
  input  logic [4:0]         rd_id,
  input  logic [ALUOP_W-1:0] alu_op_id,
  input  logic               reg_write_id,
  input  logic               mem_read_id,
  input  logic               mem_write_id,
  input  logic               flush_ex,
  input  logic               stall_mem,
  output logic               stall_id,
  output logic               valid_ex,
  output logic [XLEN-1:0]    pc_ex,
  output logic [XLEN-1:0]    rs1_data_ex,
  output logic [XLEN-1:0]    rs2_data_ex,
  output logic [XLEN-1:0]    imm_ex,
  output logic [4:0]         rs1_ex,
  output logic [4:0]         rs2_ex,
  output logic [4:0]         rd_ex,
  output logic [ALUOP_W-1:0] alu_op_ex,
  output logic               reg_write_ex,
  output logic               mem_read_ex,
  output logic               mem_write_ex,
  output logic               bubble_ex
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]        bubble_cnt
`endif
);

  ex_fields_t ex_q, ex_d;
  state_t     state_q, state_d;
  logic       hazard;
  logic       insert_bubble;

  load_use_detect u_load_use_detect (
    .valid_id    (valid_id),
    .valid_ex    (ex_q.valid),
    .mem_read_ex (ex_q.mem_read),
    .rd_ex       (ex_q.rd),
    .rs1_id      (rs1_id),
    .rs2_id      (rs2_id),
    .rs1_used_id (rs1_used_id),
    .rs2_used_id (rs2_used_id),
    .hazard      (hazard)
  );

  assign stall_id      = stall_mem | (hazard & ~flush_ex);
  assign insert_bubble = ~stall_mem & (flush_ex | hazard);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q    <= '0;
      state_q <= ST_RUN;
    end else begin
      ex_q    <= ex_d;
      state_q <= state_d;
    end
  end

  // A flush outranks the hazard, and only the hazard path marks the bubble.
  always_comb begin
    state_d = state_q;
    if (!stall_mem) begin
      if (hazard & ~flush_ex) state_d = ST_BUBBLE;
      else                    state_d = ST_RUN;
    end
  end

  always_comb begin
    ex_d = ex_q;
    if (!stall_mem) begin
      if (insert_bubble || !valid_id) begin
        ex_d = bubble_fields();
      end else begin
        ex_d.valid     = 1'b1;
        ex_d.pc        = pc_id;
        ex_d.rs1_data  = rs1_data_id;
        ex_d.rs2_data  = rs2_data_id;
        ex_d.imm       = imm_id;
        ex_d.rs1       = rs1_id;
        ex_d.rs2       = rs2_id;
        ex_d.rd        = rd_id;
        ex_d.alu_op    = alu_op_id;
        ex_d.reg_write = reg_write_id;
        ex_d.mem_read  = mem_read_id;
        ex_d.mem_write = mem_write_id;
      end
    end
  end

  always_comb begin
    bubble_ex = (state_q == ST_BUBBLE);
  end

  assign valid_ex     = ex_q.valid;
  assign pc_ex        = ex_q.pc;
  assign rs1_data_ex  = ex_q.rs1_data;
  assign rs2_data_ex  = ex_q.rs2_data;
  assign imm_ex       = ex_q.imm;
  assign rs1_ex       = ex_q.rs1;
  assign rs2_ex       = ex_q.rs2;
  assign rd_ex        = ex_q.rd;
  assign alu_op_ex    = ex_q.alu_op;
  assign reg_write_ex = ex_q.reg_write;
  assign mem_read_ex  = ex_q.mem_read;
  assign mem_write_ex = ex_q.mem_write;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (insert_bubble) bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) bubble_cnt_q <= '0;
    else        bubble_cnt_q <= bubble_cnt_d;
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized bench for id_ex_stage against an instruction-level model
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_id;
  logic [31:0] pc_id, rs1_data_id, rs2_data_id, imm_id;
  logic [4:0]  rs1_id, rs2_id, rd_id;
  logic        rs1_used_id, rs2_used_id;
  logic [3:0]  alu_op_id;
  logic        reg_write_id, mem_read_id, mem_write_id;
  logic        flush_ex, stall_mem;
  logic        stall_id, valid_ex;
  logic [31:0] pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
  logic [4:0]  rs1_ex, rs2_ex, rd_ex;
  logic [3:0]  alu_op_ex;
  logic        reg_write_ex, mem_read_ex, mem_write_ex, bubble_ex;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Model of what EX holds: one instruction record plus the bubble marker.
  logic        m_valid, m_bubble;
  logic [31:0] m_pc, m_rs1d, m_rs2d, m_imm, m_cnt;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [3:0]  m_alu;
  logic        m_rw, m_mr, m_mw;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .valid_id(valid_id), .pc_id(pc_id),
    .rs1_data_id(rs1_data_id), .rs2_data_id(rs2_data_id), .imm_id(imm_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .rd_id(rd_id), .alu_op_id(alu_op_id), .reg_write_id(reg_write_id),
    .mem_read_id(mem_read_id), .mem_write_id(mem_write_id), .flush_ex(flush_ex),
    .stall_mem(stall_mem), .stall_id(stall_id), .valid_ex(valid_ex), .pc_ex(pc_ex),
    .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex), .imm_ex(imm_ex),
    .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .alu_op_ex(alu_op_ex),
    .reg_write_ex(reg_write_ex), .mem_read_ex(mem_read_ex), .mem_write_ex(mem_write_ex),
    .bubble_ex(bubble_ex)
`ifdef ID_EX_PERF_CNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_hazard();
    if (!(valid_id && m_valid && m_mr && m_rd != 5'd0)) return 1'b0;
    return (rs1_used_id && rs1_id == m_rd) || (rs2_used_id && rs2_id == m_rd);
  endfunction

  task automatic model_kill(input logic marked);
    {m_valid, m_pc, m_rs1d, m_rs2d, m_imm} = '0;
    {m_rs1, m_rs2, m_rd, m_alu, m_rw, m_mr, m_mw} = '0;
    m_bubble = marked;
  endtask

  task automatic model_edge();
    logic hz;
    hz = model_hazard();
    if (!rst_n) begin
      model_kill(1'b0);
      m_cnt = 0;
    end else if (stall_mem) begin
      // frozen
    end else if (flush_ex) begin
      model_kill(1'b0);
      m_cnt = m_cnt + 1;
    end else if (hz) begin
      model_kill(1'b1);
      m_cnt = m_cnt + 1;
    end else if (!valid_id) begin
      model_kill(1'b0);
    end else begin
      m_valid = 1; m_bubble = 0;
      m_pc = pc_id; m_rs1d = rs1_data_id; m_rs2d = rs2_data_id; m_imm = imm_id;
      m_rs1 = rs1_id; m_rs2 = rs2_id; m_rd = rd_id; m_alu = alu_op_id;
      m_rw = reg_write_id; m_mr = mem_read_id; m_mw = mem_write_id;
    end
  endtask

  task automatic compare_all();
    chk("stall_id", 32'(stall_id), 32'(stall_mem | (model_hazard() & ~flush_ex)));
    chk("valid_ex", 32'(valid_ex), 32'(m_valid));
    chk("bubble_ex", 32'(bubble_ex), 32'(m_bubble));
    chk("pc_ex", pc_ex, m_pc);
    chk("rs1_data_ex", rs1_data_ex, m_rs1d);
    chk("rs2_data_ex", rs2_data_ex, m_rs2d);
    chk("imm_ex", imm_ex, m_imm);
    chk("regs_ex", {17'd0, rs1_ex, rs2_ex, rd_ex}, {17'd0, m_rs1, m_rs2, m_rd});
    chk("ctrl_ex", {25'd0, alu_op_ex, reg_write_ex, mem_read_ex, mem_write_ex},
        {25'd0, m_alu, m_rw, m_mr, m_mw});
`ifdef ID_EX_PERF_CNT_EN
    chk("bubble_cnt", bubble_cnt, m_cnt);
`endif
  endtask

  // Compare mid-cycle, then advance model and DUT together; returns at posedge+1.
  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic id_clear();
    valid_id = 0; pc_id = 0; rs1_data_id = 0; rs2_data_id = 0; imm_id = 0;
    rs1_id = 0; rs2_id = 0; rs1_used_id = 0; rs2_used_id = 0; rd_id = 0;
    alu_op_id = 0; reg_write_id = 0; mem_read_id = 0; mem_write_id = 0;
    flush_ex = 0; stall_mem = 0;
  endtask

  task automatic id_rand(input int pct_stall, input int pct_flush);
    valid_id = ($urandom_range(99) < 85);
    pc_id = $urandom; rs1_data_id = $urandom; rs2_data_id = $urandom; imm_id = $urandom;
    rs1_id = 5'($urandom_range(3)); rs2_id = 5'($urandom_range(3)); rd_id = 5'($urandom_range(3));
    rs1_used_id = $urandom_range(1); rs2_used_id = $urandom_range(1);
    alu_op_id = 4'($urandom); reg_write_id = $urandom_range(1);
    mem_read_id = ($urandom_range(99) < 50); mem_write_id = $urandom_range(1);
    stall_mem = ($urandom_range(99) < pct_stall);
    flush_ex = ($urandom_range(99) < pct_flush);
  endtask

  logic [31:0] cnt_snap;

  initial begin
    model_kill(1'b0);
    m_cnt = 0;
    cnt_snap = 0;
    // Reset with random ID activity
    rst_n = 0;
    id_rand(0, 30);
    @(posedge clk);
    model_edge();
    #1;
    id_rand(0, 30);
    step();
    stall_mem = 0;
    #1;
    chk("reset_valid_ex", 32'(valid_ex), 32'd0);
    chk("reset_pc_ex", pc_ex, 32'd0);
    chk("reset_stall_id", 32'(stall_id), 32'd0);
    step();
    rst_n = 1;

    // addi x5
    id_clear();
    valid_id = 1; rd_id = 5; reg_write_id = 1; alu_op_id = 4'h1; pc_id = 32'h40;
    step();
    chk("addi_valid_ex", 32'(valid_ex), 32'd1);
    chk("addi_rd_ex", 32'(rd_ex), 32'd5);
    chk("addi_bubble_ex", 32'(bubble_ex), 32'd0);

    // lw x5 then add reading x5
    id_clear();
    valid_id = 1; rd_id = 5; reg_write_id = 1; mem_read_id = 1;
    step();
    id_clear();
    valid_id = 1; rs1_id = 5; rs1_used_id = 1; rd_id = 6; reg_write_id = 1;
    #1;
    chk("lu_stall_id", 32'(stall_id), 32'd1);
    step();
    chk("lu_bubble_valid", 32'(valid_ex), 32'd0);
    chk("lu_bubble_flag", 32'(bubble_ex), 32'd1);
    chk("lu_bubble_stall_id", 32'(stall_id), 32'd0);
    step();
    chk("lu_add_rs1_ex", 32'(rs1_ex), 32'd5);
    chk("lu_add_valid", 32'(valid_ex), 32'd1);
    chk("lu_add_bubble", 32'(bubble_ex), 32'd0);

    // lw x0 never stalls
    id_clear();
    valid_id = 1; rd_id = 0; mem_read_id = 1;
    step();
    id_clear();
    valid_id = 1; rs1_id = 0; rs1_used_id = 1;
    #1;
    chk("x0_stall_id", 32'(stall_id), 32'd0);
    step();

    // unused rs2 matching a load destination
    id_clear();
    valid_id = 1; rd_id = 5; mem_read_id = 1; reg_write_id = 1;
    step();
    id_clear();
    valid_id = 1; rs1_id = 1; rs1_used_id = 1; rs2_id = 5; rs2_used_id = 0;
    #1;
    chk("unused_rs2_stall_id", 32'(stall_id), 32'd0);
    step();

    // flush beats hazard
    id_clear();
    valid_id = 1; rd_id = 5; mem_read_id = 1; reg_write_id = 1;
    step();
    id_clear();
    valid_id = 1; rs1_id = 5; rs1_used_id = 1; flush_ex = 1;
    #1;
    chk("flush_stall_id", 32'(stall_id), 32'd0);
    step();
    chk("flush_valid_ex", 32'(valid_ex), 32'd0);
    chk("flush_bubble_ex", 32'(bubble_ex), 32'd0);
    chk("flush_rd_ex", 32'(rd_ex), 32'd0);

    // stall_mem for three cycles, flush in the middle
    id_clear();
    valid_id = 1; rd_id = 7; reg_write_id = 1; pc_id = 32'h100;
    step();
`ifdef ID_EX_PERF_CNT_EN
    cnt_snap = bubble_cnt;
`endif
    for (int i = 0; i < 3; i++) begin
      id_rand(0, 0);
      stall_mem = 1;
      flush_ex = (i == 1);
      #1;
      chk("mem_stall_id", 32'(stall_id), 32'd1);
      step();
      chk("mem_stall_pc_ex", pc_ex, 32'h100);
      chk("mem_stall_rd_ex", 32'(rd_ex), 32'd7);
`ifdef ID_EX_PERF_CNT_EN
      chk("mem_stall_cnt", bubble_cnt, cnt_snap);
`endif
    end

    // randomized traffic with occasional mid-run reset
    for (int i = 0; i < 3000; i++) begin
      id_rand(15, 12);
      rst_n = ($urandom_range(199) != 0);
      step();
    end
    rst_n = 1;
    id_clear();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
